// File: rtl/imem_loader.sv
// Loads a framed program image from an 8-bit valid/ready byte stream into instruction memory.
// Holds the CPU until a frame whose checksum matches has been fully written.
module imem_loader #(
    parameter int unsigned DEPTH     = 256,
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic        in_valid,
    input  logic [7:0]  in_data,
    output logic        in_ready,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic        cpu_hold,
    output logic        done,
    output logic        error,
    output logic [15:0] words_written
);

    localparam logic [2:0] StIdle  = 3'd0;
    localparam logic [2:0] StLenLo = 3'd1;
    localparam logic [2:0] StLenHi = 3'd2;
    localparam logic [2:0] StData  = 3'd3;
    localparam logic [2:0] StCsum  = 3'd4;
    localparam logic [2:0] StDone  = 3'd5;
    localparam logic [2:0] StError = 3'd6;

    logic [2:0]  state_q, state_d;
    logic [15:0] len_q, len_d;
    logic [15:0] idx_q, idx_d;
    logic [1:0]  bcnt_q, bcnt_d;
    logic [23:0] word_q, word_d;
    logic [7:0]  csum_q, csum_d;
    logic        mem_we_q, mem_we_d;
    logic [31:0] mem_addr_q, mem_addr_d;
    logic [31:0] mem_wdata_q, mem_wdata_d;
    logic        hold_q, hold_d;
    logic        done_q, done_d;
    logic        error_q, error_d;
    logic [15:0] words_q, words_d;

    logic        accept;
    logic [15:0] len_full;

    always_comb begin
        in_ready = (state_q == StLenLo) || (state_q == StLenHi) ||
                   (state_q == StData)  || (state_q == StCsum);
    end

    assign accept   = in_valid && in_ready;
    assign len_full = {in_data, len_q[7:0]};

    always_comb begin
        state_d     = state_q;
        len_d       = len_q;
        idx_d       = idx_q;
        bcnt_d      = bcnt_q;
        word_d      = word_q;
        csum_d      = csum_q;
        mem_we_d    = 1'b0;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        hold_d      = hold_q;
        done_d      = done_q;
        error_d     = error_q;
        words_d     = words_q;

        unique case (state_q)
            StIdle, StDone, StError: begin
                if (start) begin
                    state_d = StLenLo;
                    done_d  = 1'b0;
                    error_d = 1'b0;
                    words_d = 16'd0;
                    csum_d  = 8'd0;
                    hold_d  = 1'b1;
                end
            end
            StLenLo: begin
                if (accept) begin
                    len_d   = {8'd0, in_data};
                    state_d = StLenHi;
                end
            end
            StLenHi: begin
                if (accept) begin
                    len_d  = len_full;
                    idx_d  = 16'd0;
                    bcnt_d = 2'd0;
                    if (32'(len_full) > DEPTH) begin
                        state_d = StError;
                        error_d = 1'b1;
                    end else if (len_full == 16'd0) begin
                        state_d = StCsum;
                    end else begin
                        state_d = StData;
                    end
                end
            end
            StData: begin
                if (accept) begin
                    csum_d = csum_q ^ in_data;
                    bcnt_d = bcnt_q + 2'd1;
                    if (bcnt_q == 2'd3) begin
                        // Registered write strobe lands in the cycle after the 4th byte
                        mem_we_d    = 1'b1;
                        mem_wdata_d = {in_data, word_q};
                        mem_addr_d  = BASE_ADDR + {14'd0, idx_q, 2'b00};
                        words_d     = words_q + 16'd1;
                        idx_d       = idx_q + 16'd1;
                        if ((idx_q + 16'd1) == len_q) begin
                            state_d = StCsum;
                        end
                    end else begin
                        word_d[8*bcnt_q +: 8] = in_data;
                    end
                end
            end
            StCsum: begin
                if (accept) begin
                    if (in_data == csum_q) begin
                        state_d = StDone;
                        done_d  = 1'b1;
                        hold_d  = 1'b0;
                    end else begin
                        state_d = StError;
                        error_d = 1'b1;
                        hold_d  = 1'b1;
                    end
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= StIdle;
            len_q       <= 16'd0;
            idx_q       <= 16'd0;
            bcnt_q      <= 2'd0;
            word_q      <= 24'd0;
            csum_q      <= 8'd0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= 32'd0;
            mem_wdata_q <= 32'd0;
            hold_q      <= 1'b1;
            done_q      <= 1'b0;
            error_q     <= 1'b0;
            words_q     <= 16'd0;
        end else begin
            state_q     <= state_d;
            len_q       <= len_d;
            idx_q       <= idx_d;
            bcnt_q      <= bcnt_d;
            word_q      <= word_d;
            csum_q      <= csum_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            hold_q      <= hold_d;
            done_q      <= done_d;
            error_q     <= error_d;
            words_q     <= words_d;
        end
    end

    assign mem_we        = mem_we_q;
    assign mem_addr      = mem_addr_q;
    assign mem_wdata     = mem_wdata_q;
    assign cpu_hold      = hold_q;
    assign done          = done_q;
    assign error         = error_q;
    assign words_written = words_q;

endmodule

// File: tb/tb_imem_loader.sv
// Randomized bench for imem_loader: frames are built here, the expected write sequence and
// final status are derived from the frame contents, and a per-cycle monitor checks the DUT.
module tb_imem_loader;

    localparam int unsigned DEPTH     = 256;
    localparam logic [31:0] BASE_ADDR = 32'h0000_0000;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic        in_valid;
    logic [7:0]  in_data;
    logic        in_ready;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        cpu_hold;
    logic        done;
    logic        error;
    logic [15:0] words_written;

    imem_loader #(.DEPTH(DEPTH), .BASE_ADDR(BASE_ADDR)) dut (
        .clk(clk), .reset(reset), .start(start), .in_valid(in_valid), .in_data(in_data),
        .in_ready(in_ready), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .cpu_hold(cpu_hold), .done(done), .error(error), .words_written(words_written)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
        int          idx;
    } wr_t;

    int          total = 0;
    int          bad = 0;
    wr_t         exp_q[$];
    wr_t         e;
    int          exp_words = 0;
    logic [31:0] log_addr[$];
    logic [31:0] log_data[$];
    logic [31:0] fw[$];
    logic        spurious;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %h want %h at %0t", name, act, req, $time);
        end
    endtask

    // Per-cycle monitor, sampled 1 time unit after each rising edge
    always @(posedge clk) begin
        #1;
        if (!reset) begin
            spurious = mem_we && (exp_q.size() == 0);
            chk("spurious_we", 32'(spurious), 32'd0);
            if (mem_we && exp_q.size() != 0) begin
                log_addr.push_back(mem_addr);
                log_data.push_back(mem_wdata);
                e = exp_q.pop_front();
                chk("we_addr", mem_addr, e.addr);
                chk("we_data", mem_wdata, e.data);
                exp_words = e.idx + 1;
            end
            chk("words_written", 32'(words_written), 32'(exp_words));
            chk("hold_vs_done", 32'(cpu_hold), 32'(!done));
            if (done || error) chk("ready_in_final", 32'(in_ready), 32'd0);
        end
    end

    task automatic check_reset_values(input string tag);
        chk({tag, "_in_ready"}, 32'(in_ready), 32'd0);
        chk({tag, "_mem_we"}, 32'(mem_we), 32'd0);
        chk({tag, "_mem_addr"}, mem_addr, 32'd0);
        chk({tag, "_mem_wdata"}, mem_wdata, 32'd0);
        chk({tag, "_cpu_hold"}, 32'(cpu_hold), 32'd1);
        chk({tag, "_done"}, 32'(done), 32'd0);
        chk({tag, "_error"}, 32'(error), 32'd0);
        chk({tag, "_words"}, 32'(words_written), 32'd0);
    endtask

    task automatic send_byte(input logic [7:0] b, input int gapmax, input bit noise);
        int g = (gapmax > 0) ? int'($urandom_range(gapmax, 0)) : 0;
        int t = 0;
        repeat (g) begin
            @(negedge clk);
            in_valid = 1'b0;
            start = noise && ($urandom_range(3, 0) == 0);
        end
        @(negedge clk);
        in_valid = 1'b1;
        in_data = b;
        start = noise && ($urandom_range(2, 0) == 0);
        while (!in_ready && t < 20) begin
            @(negedge clk);
            t++;
        end
        chk("byte_ready", 32'(in_ready), 32'd1);
    endtask

    task automatic begin_frame();
        @(negedge clk);
        in_valid = 1'b0;
        start = 1'b1;
        exp_words = 0;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic end_stream();
        @(negedge clk);
        in_valid = 1'b0;
        start = 1'b0;
    endtask

    // Sends the words in fw as one frame; csum_delta != 0 corrupts the checksum byte
    task automatic send_frame(input logic [7:0] csum_delta, input int gapmax, input bit noise);
        int n = fw.size();
        logic [7:0] cs = 8'd0;
        logic [7:0] b;
        int t = 0;
        for (int i = 0; i < n; i++) begin
            exp_q.push_back('{addr: BASE_ADDR + 32'(4 * i), data: fw[i], idx: i});
        end
        begin_frame();
        send_byte(8'(n), gapmax, noise);
        send_byte(8'(n >> 8), gapmax, noise);
        for (int i = 0; i < n; i++) begin
            for (int k = 0; k < 4; k++) begin
                b = 8'(fw[i] >> (8 * k));
                cs = cs ^ b;
                send_byte(b, gapmax, noise);
            end
        end
        send_byte(cs ^ csum_delta, gapmax, noise);
        end_stream();
        while (!(done || error) && t < 10) begin
            @(negedge clk);
            t++;
        end
        chk("frame_done", 32'(done), 32'(csum_delta == 8'd0));
        chk("frame_error", 32'(error), 32'(csum_delta != 8'd0));
        chk("frame_hold", 32'(cpu_hold), 32'(csum_delta != 8'd0));
        chk("frame_words", 32'(words_written), 32'(n));
        chk("frame_pending", 32'(exp_q.size()), 32'd0);
        chk("frame_ready", 32'(in_ready), 32'd0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1;
        start = 1'b0;
        in_valid = 1'b0;
        in_data = 8'd0;
        #12;
        check_reset_values("por");
        @(negedge clk);
        reset = 1'b0;
        repeat (2) @(negedge clk);
        check_reset_values("idle");

        // Known two-word image, good checksum 0x31
        fw = '{32'h0000_0013, 32'hDEAD_BEEF};
        log_addr.delete();
        log_data.delete();
        send_frame(8'h00, 0, 1'b0);
        chk("t1_nwrites", 32'(log_addr.size()), 32'd2);
        if (log_addr.size() == 2) begin
            chk("t1_addr0", log_addr[0], 32'h0);
            chk("t1_data0", log_data[0], 32'h0000_0013);
            chk("t1_addr1", log_addr[1], 32'h4);
            chk("t1_data1", log_data[1], 32'hDEAD_BEEF);
        end

        // Same image, checksum byte 0x30
        log_addr.delete();
        send_frame(8'h01, 0, 1'b0);
        chk("t2_nwrites", 32'(log_addr.size()), 32'd2);

        // N = 257 exceeds DEPTH
        begin_frame();
        send_byte(8'h01, 0, 1'b0);
        send_byte(8'h01, 0, 1'b0);
        end_stream();
        chk("ovf_error", 32'(error), 32'd1);
        chk("ovf_done", 32'(done), 32'd0);
        chk("ovf_ready", 32'(in_ready), 32'd0);
        chk("ovf_words", 32'(words_written), 32'd0);
        // Bytes offered while not ready are ignored
        in_valid = 1'b1;
        in_data = 8'h00;
        repeat (3) @(negedge clk);
        in_valid = 1'b0;
        chk("ovf_hold_error", 32'(error), 32'd1);
        chk("ovf_hold_hold", 32'(cpu_hold), 32'd1);

        // Empty frame, then a one-word frame
        fw.delete();
        send_frame(8'h00, 0, 1'b0);
        fw = '{32'h1234_5678};
        send_frame(8'h00, 0, 1'b0);

        // Randomized frames with stream gaps and stray start pulses
        for (int f = 0; f < 10; f++) begin
            int n = int'($urandom_range(6, 1));
            fw.delete();
            for (int i = 0; i < n; i++) fw.push_back($urandom);
            send_frame(($urandom_range(3, 0) == 0) ? 8'(1 << $urandom_range(7, 0)) : 8'h00,
                       3, 1'b1);
        end

        // Largest accepted length
        fw.delete();
        for (int i = 0; i < int'(DEPTH); i++) fw.push_back($urandom);
        send_frame(8'h00, 0, 1'b0);

        // Reset after 6 data bytes of a two-word frame
        exp_q.push_back('{addr: BASE_ADDR, data: 32'hCAFE_F00D, idx: 0});
        begin_frame();
        send_byte(8'h02, 0, 1'b0);
        send_byte(8'h00, 0, 1'b0);
        send_byte(8'h0D, 0, 1'b0);
        send_byte(8'hF0, 0, 1'b0);
        send_byte(8'hFE, 0, 1'b0);
        send_byte(8'hCA, 0, 1'b0);
        send_byte(8'h11, 0, 1'b0);
        send_byte(8'h22, 0, 1'b0);
        @(negedge clk);
        in_valid = 1'b0;
        reset = 1'b1;
        chk("rst_pending", 32'(exp_q.size()), 32'd0);
        exp_q.delete();
        exp_words = 0;
        #1;
        check_reset_values("midrst");
        @(negedge clk);
        reset = 1'b0;
        in_valid = 1'b1;
        in_data = 8'h33;
        repeat (5) @(negedge clk);
        in_valid = 1'b0;
        check_reset_values("postrst");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
